// File: rtl/song_recorder.sv
// song_recorder: turns beat pulses and note events into WAIT/NOTE/END words for a song RAM.
// Define SONG_RECORDER_ENTRY_CNT_EN to add the entry_count output.
module song_recorder (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        record,
    input  logic [1:0]  song,
    input  logic        beat,
    input  logic [5:0]  note_in,
    input  logic [5:0]  duration_in,
    input  logic        note_valid,
    output logic        note_ready,
    output logic        wr_en,
    output logic [8:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic        recording,
    output logic        rec_done,
    output logic        overflow
`ifdef SONG_RECORDER_ENTRY_CNT_EN
    ,
    output logic [7:0]  entry_count
`endif
);

    localparam int unsigned IDX_W  = 7;
    localparam int unsigned BEAT_W = 6;
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(127);
    localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(63);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REC,
        S_WR_WAIT,
        S_WR_NOTE,
        S_WR_END,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          song_q, song_d;
    logic [IDX_W-1:0]    index_q, index_d;
    logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic                held_q, held_d;
    logic [5:0]          hold_note_q, hold_note_d;
    logic [5:0]          hold_dur_q, hold_dur_d;
    logic                armed_q, armed_d;
    logic                overflow_d;
    logic                note_ready_d, wr_en_d, recording_d, rec_done_d;
    logic [8:0]          wr_addr_d;
    logic [15:0]         wr_data_d;
    logic [BEAT_W-1:0]   cnt_inc;
    logic [IDX_W-1:0]    idx_inc;
    logic                note_ok;
`ifdef SONG_RECORDER_ENTRY_CNT_EN
    logic [7:0]          entry_cnt_q, entry_cnt_d;
`endif

    // Next-state, datapath and next-output logic; outputs are registered from the *_d values
    always_comb begin
        state_d      = state_q;
        song_d       = song_q;
        index_d      = index_q;
        beat_cnt_d   = beat_cnt_q;
        held_d       = held_q;
        hold_note_d  = hold_note_q;
        hold_dur_d   = hold_dur_q;
        armed_d      = armed_q;
        overflow_d   = overflow;
        cnt_inc      = (beat && (beat_cnt_q != BEAT_MAX)) ? beat_cnt_q + BEAT_W'(1) : beat_cnt_q;
        idx_inc      = index_q + IDX_W'(1);
        note_ok      = note_valid && ((note_in != 6'd0) || (duration_in != 6'd0));

        case (state_q)
            S_IDLE: begin
                if (!record) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    song_d     = song;
                    index_d    = '0;
                    beat_cnt_d = '0;
                    overflow_d = 1'b0;
                    held_d     = 1'b0;
                    armed_d    = 1'b0;
                    state_d    = S_REC;
                end
            end
            S_REC: begin
                // A beat coinciding with a note or record drop counts into the pending WAIT
                beat_cnt_d = cnt_inc;
                if (!record) begin
                    state_d = (cnt_inc != '0) ? S_WR_WAIT : S_WR_END;
                end else if (index_q == IDX_LAST) begin
                    overflow_d = 1'b1;
                    state_d    = S_WR_END;
                end else if (beat_cnt_q == BEAT_MAX) begin
                    state_d = S_WR_WAIT;
                end else if (note_ok) begin
                    held_d      = 1'b1;
                    hold_note_d = note_in;
                    hold_dur_d  = duration_in;
                    state_d     = (cnt_inc != '0) ? S_WR_WAIT : S_WR_NOTE;
                end
            end
            S_WR_WAIT: begin
                index_d    = idx_inc;
                beat_cnt_d = beat ? BEAT_W'(1) : BEAT_W'(0);
                if (idx_inc == IDX_LAST) begin
                    // Capacity reached while the take was still live: truncated
                    if (held_q || record) overflow_d = 1'b1;
                    held_d  = 1'b0;
                    state_d = S_WR_END;
                end else if (held_q) begin
                    state_d = S_WR_NOTE;
                end else if (!record) begin
                    state_d = S_WR_END;
                end else begin
                    state_d = S_REC;
                end
            end
            S_WR_NOTE: begin
                index_d    = idx_inc;
                held_d     = 1'b0;
                beat_cnt_d = cnt_inc;
                if (idx_inc == IDX_LAST) begin
                    if (record) overflow_d = 1'b1;
                    state_d = S_WR_END;
                end else if (!record) begin
                    state_d = S_WR_END;
                end else begin
                    state_d = S_REC;
                end
            end
            S_WR_END: state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        wr_en_d      = (state_d == S_WR_WAIT) || (state_d == S_WR_NOTE) || (state_d == S_WR_END);
        wr_addr_d    = {song_d, index_d};
        wr_data_d    = 16'h0000;
        if (state_d == S_WR_WAIT) wr_data_d = {1'b1, beat_cnt_d, 9'd0};
        if (state_d == S_WR_NOTE) wr_data_d = {1'b0, hold_note_d, hold_dur_d, 3'b000};
        recording_d  = (state_d != S_IDLE) && (state_d != S_DONE);
        rec_done_d   = (state_d == S_DONE);
        note_ready_d = (state_d == S_REC) && (beat_cnt_d != BEAT_MAX);

`ifdef SONG_RECORDER_ENTRY_CNT_EN
        entry_cnt_d = entry_cnt_q;
        if ((state_q == S_IDLE) && (state_d == S_REC)) entry_cnt_d = 8'd0;
        else if (wr_en_d) entry_cnt_d = entry_cnt_q + 8'd1;
`endif
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            song_q      <= '0;
            index_q     <= '0;
            beat_cnt_q  <= '0;
            held_q      <= 1'b0;
            hold_note_q <= '0;
            hold_dur_q  <= '0;
            armed_q     <= 1'b0;
            overflow    <= 1'b0;
            note_ready  <= 1'b0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            recording   <= 1'b0;
            rec_done    <= 1'b0;
        end else begin
            state_q     <= state_d;
            song_q      <= song_d;
            index_q     <= index_d;
            beat_cnt_q  <= beat_cnt_d;
            held_q      <= held_d;
            hold_note_q <= hold_note_d;
            hold_dur_q  <= hold_dur_d;
            armed_q     <= armed_d;
            overflow    <= overflow_d;
            note_ready  <= note_ready_d;
            wr_en       <= wr_en_d;
            wr_addr     <= wr_addr_d;
            wr_data     <= wr_data_d;
            recording   <= recording_d;
            rec_done    <= rec_done_d;
        end
    end

`ifdef SONG_RECORDER_ENTRY_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) entry_cnt_q <= 8'd0;
        else          entry_cnt_q <= entry_cnt_d;
    end

    assign entry_count = entry_cnt_q;
`endif

endmodule

// File: tb/tb_song_recorder.sv
// tb_song_recorder: directed takes with a write scoreboard checked by a negedge monitor.
module tb_song_recorder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        record;
    logic [1:0]  song;
    logic        beat;
    logic [5:0]  note_in;
    logic [5:0]  duration_in;
    logic        note_valid;
    logic        note_ready;
    logic        wr_en;
    logic [8:0]  wr_addr;
    logic [15:0] wr_data;
    logic        recording;
    logic        rec_done;
    logic        overflow;
`ifdef SONG_RECORDER_ENTRY_CNT_EN
    logic [7:0]  entry_count;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    logic [24:0] exp_q[$];
    int wr_cyc_q[$];

    song_recorder dut (
        .clk(clk),
        .reset_n(reset_n),
        .record(record),
        .song(song),
        .beat(beat),
        .note_in(note_in),
        .duration_in(duration_in),
        .note_valid(note_valid),
        .note_ready(note_ready),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .recording(recording),
        .rec_done(rec_done),
        .overflow(overflow)
`ifdef SONG_RECORDER_ENTRY_CNT_EN
        ,
        .entry_count(entry_count)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe pops one expected {addr,data}
    always @(negedge clk) begin
        if (reset_n === 1'b1 && wr_en === 1'b1) begin
            wr_cnt++;
            wr_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h with empty scoreboard", wr_addr, wr_data);
            end else begin
                check("write", {7'd0, wr_addr, wr_data}, {7'd0, exp_q.pop_front()});
            end
        end
        if (reset_n === 1'b1 && rec_done === 1'b1) done_cnt++;
    end

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_wr(input logic [8:0] a, input logic [15:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic wait_ready();
        int k;
        for (k = 0; k < 200 && note_ready !== 1'b1; k++) tick();
        if (note_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL timeout_note_ready: got 0 expected 1");
        end
    endtask

    task automatic start_take(input logic [1:0] s);
        record = 1'b0;
        tick(2);
        record = 1'b1;
        song = s;
        wr_cnt = 0;
        wr_cyc_q.delete();
        wait_ready();
    endtask

    task automatic send_note(input logic [5:0] n, input logic [5:0] d);
        note_in = n;
        duration_in = d;
        note_valid = 1'b1;
        tick();
        note_valid = 1'b0;
    endtask

    task automatic send_beat();
        beat = 1'b1;
        tick();
        beat = 1'b0;
    endtask

    task automatic end_take();
        int start;
        start = done_cnt;
        record = 1'b0;
        for (int k = 0; k < 50 && done_cnt == start; k++) tick();
        check("rec_done_pulse", 32'(done_cnt - start), 32'd1);
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wr_en"}, 32'(wr_en), 32'd0);
        check({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
        check({tag, "_wr_data"}, 32'(wr_data), 32'd0);
        check({tag, "_note_ready"}, 32'(note_ready), 32'd0);
        check({tag, "_recording"}, 32'(recording), 32'd0);
        check({tag, "_rec_done"}, 32'(rec_done), 32'd0);
        check({tag, "_overflow"}, 32'(overflow), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        record = 1'b0;
        song = 2'd0;
        beat = 1'b0;
        note_in = 6'd0;
        duration_in = 6'd0;
        note_valid = 1'b0;
        tick(3);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        tick(2);

        // Note with no prior beats, then record low
        start_take(2'd2);
        expect_wr(9'h100, 16'h2820);
        send_note(6'd20, 6'd4);
        wait_ready();
        expect_wr(9'h101, 16'h0000);
        end_take();
        check("t1_overflow", 32'(overflow), 32'd0);
        check("t1_writes", 32'(wr_cnt), 32'd2);

        // Fourth beat coincides with the note: WAIT(4) then NOTE back to back
        start_take(2'd0);
        for (int i = 0; i < 3; i++) begin
            send_beat();
            tick();
        end
        expect_wr(9'h000, 16'h8800);
        expect_wr(9'h001, 16'h1410);
        beat = 1'b1;
        send_note(6'd10, 6'd2);
        beat = 1'b0;
        wait_ready();
        expect_wr(9'h002, 16'h0000);
        end_take();
        if (wr_cyc_q.size() >= 2) check("t2_back_to_back", 32'(wr_cyc_q[1] - wr_cyc_q[0]), 32'd1);
        else check("t2_write_count", 32'(wr_cyc_q.size()), 32'd3);

        // 70 beats, no notes: flush at 63 then the remainder
        start_take(2'd1);
        expect_wr(9'h080, 16'hFE00);
        for (int i = 0; i < 70; i++) begin
            send_beat();
            tick(2);
        end
        expect_wr(9'h081, 16'h8E00);
        expect_wr(9'h082, 16'h0000);
        end_take();
        check("t3_writes", 32'(wr_cnt), 32'd3);

        // 128 notes: slots 0-126 notes, slot 127 END, overflow set
        begin
            int start;
            start = done_cnt;
            start_take(2'd3);
            for (int i = 0; i < 128; i++) begin
                logic [5:0] n;
                logic [5:0] d;
                n = 6'((i % 63) + 1);
                d = 6'(i % 64);
                for (int k = 0; k < 50 && note_ready !== 1'b1 && recording === 1'b1; k++) tick();
                if (note_ready !== 1'b1) begin
                    check("t4_take_ended_after_127", 32'(i), 32'd127);
                    send_note(n, d);
                    break;
                end
                expect_wr({2'd3, 7'(i)}, {1'b0, n, d, 3'b000});
                if (i == 126) expect_wr({2'd3, 7'd127}, 16'h0000);
                send_note(n, d);
            end
            for (int k = 0; k < 50 && recording === 1'b1; k++) tick();
            tick(3);
            check("t4_rec_done", 32'(done_cnt - start), 32'd1);
            check("t4_overflow", 32'(overflow), 32'd1);
            check("t4_writes", 32'(wr_cnt), 32'd128);
            check("t4_no_restart", 32'(recording), 32'd0);
`ifdef SONG_RECORDER_ENTRY_CNT_EN
            check("t4_entry_count", 32'(entry_count), 32'd128);
`endif
            record = 1'b0;
            tick();
            check("t4_overflow_sticky", 32'(overflow), 32'd1);
        end

        // Null note ignored; note during WR_WAIT dropped
        start_take(2'd0);
        check("t5_overflow_cleared", 32'(overflow), 32'd0);
        send_note(6'd0, 6'd0);
        send_beat();
        send_beat();
        expect_wr(9'h000, 16'h8400);
        expect_wr(9'h001, 16'h0A18);
        send_note(6'd5, 6'd3);
        check("t5_ready_in_wr_wait", 32'(note_ready), 32'd0);
        send_note(6'd7, 6'd7);
        wait_ready();
        expect_wr(9'h002, 16'h0000);
        end_take();
        check("t5_writes", 32'(wr_cnt), 32'd3);

        // Reset during WR_NOTE: immediate reset values, no END written
        start_take(2'd1);
        send_note(6'd9, 6'd9);
        check("t6_in_wr_note", 32'(wr_en), 32'd1);
        #2;
        reset_n = 1'b0;
        record = 1'b0;
        #1;
        check_reset_outputs("midreset");
        tick(2);
        reset_n = 1'b1;
        wr_cnt = 0;
        tick(10);
        check("t6_no_writes", 32'(wr_cnt), 32'd0);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/song_recorder.md
SONG_RECORDER -- requirements
Module: song_recorder

Interface
REQ-001 The block SHALL have exactly one clock and an asynchronous, active-low reset, with ports as listed below.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 record  input  1  level; high requests recording, falling while recording ends the take.
REQ-005 song  input  2  song slot; latched at take start, forms wr_addr[8:7].
REQ-006 beat  input  1  one-cycle beat pulse.
REQ-007 note_in  input  6  note number to record.
REQ-008 duration_in  input  6  note duration in beats.
REQ-009 note_valid  input  1  one-cycle note event; accepted only while note_ready=1.
REQ-010 note_ready  output  1  high only in REC with beat_cnt<63 and no flush pending.
REQ-011 wr_en  output  1  song-RAM write strobe, one cycle per entry.
REQ-012 wr_addr  output  9  {latched song, index[6:0]}.
REQ-013 wr_data  output  16  entry word.
REQ-014 recording  output  1  high in every state except IDLE and DONE.
REQ-015 rec_done  output  1  one-cycle pulse when the take closes.
REQ-016 overflow  output  1  sticky; set when the take was truncated, cleared at next take start.

Function
REQ-017 Entry formats SHALL be: NOTE = {1'b0, note[5:0], dur[5:0], 3'b000}; WAIT = {1'b1, beats[5:0], 9'd0}; END = 16'h0000.
REQ-018 States SHALL be IDLE, REC, WR_WAIT, WR_NOTE, WR_END, DONE; wr_en=1 exactly in WR_WAIT, WR_NOTE, WR_END.
REQ-019 IDLE: on record=1, latch song, clear index, beat_cnt and overflow, then enter REC next cycle.
REQ-020 REC: each beat pulse SHALL increment the 6-bit beat_cnt.
REQ-021 REC priority, highest first: record=0 -> WR_WAIT if beat_cnt>0, else WR_END; index=127 -> WR_END with overflow set; beat_cnt=63 -> WR_WAIT (flush); accepted note_valid -> WR_WAIT if beat_cnt>0, else WR_NOTE.
REQ-022 A note_valid with note_in=0 and duration_in=0 SHALL be ignored, since it would encode END.
REQ-023 An accepted note SHALL latch note_in/duration_in into a holding register; note_valid while note_ready=0 SHALL be dropped.
REQ-024 A beat and a note_valid in the same REC cycle SHALL count the beat into the preceding WAIT.
REQ-025 WR_WAIT SHALL write WAIT(beat_cnt) at index, increment index, and reload beat_cnt with 1 if beat is high in that cycle, else 0.
REQ-026 After WR_WAIT, the block SHALL go to: WR_END if index is now 127; else WR_NOTE if a note is held; else WR_END if record=0; else REC.
REQ-027 When the held note is lost to the index=127 rule, overflow SHALL be set.
REQ-028 WR_NOTE SHALL write the held note, increment index, then enter WR_END if index=127 or record=0, else REC.
REQ-029 Beats arriving in WR_NOTE SHALL increment beat_cnt.
REQ-030 WR_END SHALL write END at index without incrementing it, then enter DONE.
REQ-031 DONE SHALL assert rec_done for one cycle, then enter IDLE; a new take requires record=0 observed in IDLE first.
REQ-032 Note-to-write latency SHALL be: note_valid at cycle t with beat_cnt=0 gives the NOTE write at t+1; with beat_cnt>0, the WAIT write is at t+1 and the NOTE write at t+2.
REQ-033 A take SHALL never write more than 128 entries, and slot 127 SHALL only ever hold END.

Reset
REQ-034 On reset_n=0, state SHALL go to IDLE immediately, independent of clk.
REQ-035 Reset SHALL clear index, beat_cnt, the held note and the latched song.
REQ-036 Reset SHALL drive wr_en=0, wr_addr=0, wr_data=0, note_ready=0, recording=0, rec_done=0 and overflow=0.
REQ-037 Reset mid-take SHALL write no END entry; the partial take is left unterminated.

Configuration
REQ-038 With SONG_RECORDER_ENTRY_CNT_EN defined, an extra output entry_count[7:0] SHALL report the entries written in the current or last take, including END.
REQ-039 entry_count SHALL reset to 0, clear at take start and hold after DONE.
REQ-040 Without SONG_RECORDER_ENTRY_CNT_EN, the port and its counter SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-041 song=2; record high; note 20/dur 4 with no prior beats; record low -> writes 0x100:{0,20,4,000}, 0x101:0x0000, then rec_done pulse.
REQ-042 Three beats, then note 10/dur 2 in the same cycle as a fourth beat -> WAIT(4)=0x8800 at index 0 and NOTE 0x1410 at index 1 in consecutive cycles.
REQ-043 70 beats with no notes, then record low -> WAIT(63)=0xFE00, WAIT(7)=0x8E00, END; three writes total.
REQ-044 128 single-cycle notes with beat_cnt=0 -> indices 0-126 hold notes, index 127 holds END, overflow=1, rec_done pulse.
REQ-045 reset_n pulsed low mid-WR_NOTE -> outputs go to reset values asynchronously and no further writes occur.
REQ-046 note_valid with note_in=0 and duration_in=0, plus note_valid during WR_WAIT -> no entries written for either.
